// File: rtl/ram_rdr_pkg.sv
// Shared types and sizing helpers for the RAM burst reader.
package ram_rdr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } rdr_state_t;

  localparam int unsigned RDR_DEF_WIDTH     = 8;
  localparam int unsigned RDR_DEF_LOCATIONS = 32;

  function automatic int unsigned rdr_aw(input int unsigned locs);
    return (locs > 1) ? $clog2(locs) : 1;
  endfunction

endpackage

// File: rtl/ram_rdr_skid.sv
// Two-entry data+last FIFO with flow-through: when empty, the incoming RAM word
// is presented directly and only captured if the consumer does not take it.
module ram_rdr_skid #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  input  logic          i_last,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_last,
  output logic [1:0]    o_count
);

  logic [DW:0] r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        w_empty;
  logic        w_wr;
  logic        w_rd;

  assign w_empty = (r_count == 2'd0);
  assign o_valid = ~w_empty | i_valid;
  assign o_data  = !w_empty ? r_mem[r_rd_ptr][DW-1:0] : (i_valid ? i_data : '0);
  assign o_last  = !w_empty ? r_mem[r_rd_ptr][DW]     : (i_valid & i_last);
  assign o_count = r_count;

  // Store the incoming word unless it bypasses straight to a ready consumer.
  assign w_rd = ~w_empty & i_ready;
  assign w_wr = i_valid & ~(w_empty & i_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= ~r_wr_ptr;
      if (w_rd) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_wr} - {1'b0, w_rd};
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {i_last, i_data};
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read initiator for a 1-cycle-latency RAM, streaming words out on valid/ready.
// Build option: ADDR_WRAP_EN (addresses wrap modulo locations; range errors disabled).
module ram_burst_reader
  import ram_rdr_pkg::*;
#(
  parameter  int unsigned length    = RDR_DEF_WIDTH,
  parameter  int unsigned locations = RDR_DEF_LOCATIONS,
  localparam int unsigned AW        = rdr_aw(locations),
  localparam int unsigned LW        = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  input  logic [LW-1:0]     burst_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_rd_en,
  output logic [AW-1:0]     ram_r_addr,
  input  logic [length-1:0] ram_rdata,
  output logic [length-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  rdr_state_t        r_state;
  rdr_state_t        w_state_nxt;
  logic [AW-1:0]     r_addr;
  logic [LW-1:0]     r_rd_left;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_err;
  logic              w_rd_en;
  logic              w_last_rd;
  logic              w_range_bad;
  logic              w_valid;
  logic              w_pop;
  logic              w_room;
  logic [1:0]        w_count;
  logic [1:0]        w_outstanding;
  logic [AW-1:0]     w_addr_nxt;

`ifdef ADDR_WRAP_EN
  assign w_range_bad = 1'b0;
`else
  logic [LW:0] w_end;
  assign w_end       = {2'b00, base_addr} + {1'b0, burst_len};
  assign w_range_bad = (w_end > (LW+1)'(locations));
`endif

  assign w_pop         = w_valid & m_ready;
  assign w_outstanding = w_count + {1'b0, r_inflight};
  // A beat leaving this cycle frees a slot, which keeps one read per cycle at full rate.
  assign w_room        = (w_outstanding < 2'd2) | ((w_outstanding == 2'd2) & w_pop);
  assign w_last_rd     = (r_rd_left == LW'(1));
  assign w_addr_nxt    = (r_addr == AW'(locations - 1)) ? '0 : r_addr + AW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if ((burst_len == '0) || w_range_bad) w_state_nxt = DONE;
          else                                  w_state_nxt = READ;
        end
      end
      READ: begin
        if (w_room) begin
          w_rd_en = 1'b1;
          if (w_last_rd) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pop && m_last) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_rd_left       <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_inflight      <= w_rd_en;
      r_inflight_last <= w_rd_en & w_last_rd;
      if ((r_state == IDLE) && start) begin
        r_addr    <= base_addr;
        r_rd_left <= burst_len;
        r_err     <= w_range_bad;
      end else if (w_rd_en) begin
        r_addr    <= w_addr_nxt;
        r_rd_left <= r_rd_left - LW'(1);
      end
    end
  end

  ram_rdr_skid #(
    .DW (length)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (r_inflight),
    .i_data  (ram_rdata),
    .i_last  (r_inflight_last),
    .i_ready (m_ready),
    .o_valid (w_valid),
    .o_data  (m_data),
    .o_last  (m_last),
    .o_count (w_count)
  );

  assign m_valid    = w_valid;
  assign ram_rd_en  = w_rd_en;
  assign ram_r_addr = r_addr;
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign err        = (r_state == DONE) & r_err;

endmodule
